// File: rtl/std_sram_singleport_arbiter_pkg.sv
// Shared encodings for the single-port SRAM arbiter: controller states and requester IDs.
package std_sram_singleport_arbiter_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic ID_M0 = 1'b0;
  localparam logic ID_M1 = 1'b1;

endpackage

// File: rtl/std_rr_arbiter2.sv
// Two-way round-robin grant. The pointer names the requester that has priority
// on a tie and moves to the loser only when the grant is actually accepted.
module std_rr_arbiter2
  import std_sram_singleport_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic accept,
  output logic grant0,
  output logic grant1
);

  logic ptr;

  assign grant0 = req0 & (~req1 | (ptr == ID_M0));
  assign grant1 = req1 & (~req0 | (ptr == ID_M1));

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= ID_M0;
    end else if (accept) begin
      ptr <= grant0 ? ID_M1 : ID_M0;
    end
  end

endmodule

// File: rtl/std_sram_singleport_arbiter.sv
// Shares one single-port SRAM between two requesters: zero-fill sweep after reset,
// then one round-robin access per cycle with fixed-latency read return.
module std_sram_singleport_arbiter
  import std_sram_singleport_arbiter_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 6,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    RD_LATENCY  = 2,
  parameter int                    INIT_ENABLE = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  init_done,
  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_din,
  output logic                  m0_rsp_valid,
  output logic [DATA_WIDTH-1:0] m0_rsp_data,
  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_din,
  output logic                  m1_rsp_valid,
  output logic [DATA_WIDTH-1:0] m1_rsp_data,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  sram_regrstn
);

  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  init_done_q;
  logic                  run_active;
  logic                  grant0, grant1;
  logic                  accept;
  logic                  rd_issue;
  logic [RD_LATENCY-1:0] pipe_v;
  logic [RD_LATENCY-1:0] pipe_id;
  logic                  rsp_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= (INIT_ENABLE != 0) ? ST_INIT : ST_RUN;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= (state_d == ST_RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + CNT_ONE;
      if (cnt_q == CNT_LAST) state_d = ST_RUN;
    end
  end

  // init_done_q also masks the first cycle after reset when the sweep is skipped
  assign run_active = (state_q == ST_RUN) & init_done_q & ~reset;
  assign m0_ready   = run_active & grant0;
  assign m1_ready   = run_active & grant1;
  assign accept     = m0_ready | m1_ready;
  assign init_done  = init_done_q & ~reset;

  std_rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req0   (m0_valid),
    .req1   (m1_valid),
    .accept (accept),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  always_comb begin
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    if (!reset) begin
      if (state_q == ST_INIT) begin
        sram_en   = 1'b1;
        sram_we   = 1'b1;
        sram_addr = cnt_q[ADDR_WIDTH-1:0];
        sram_din  = INIT_VALUE;
      end else if (m0_ready) begin
        sram_en   = 1'b1;
        sram_we   = m0_we;
        sram_addr = m0_addr;
        sram_din  = m0_din;
      end else if (m1_ready) begin
        sram_en   = 1'b1;
        sram_we   = m1_we;
        sram_addr = m1_addr;
        sram_din  = m1_din;
      end
    end
  end

  assign sram_regrstn = ~reset;

  assign rd_issue = (m0_ready & ~m0_we) | (m1_ready & ~m1_we);

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_v  <= '0;
      pipe_id <= '0;
    end else begin
      pipe_v[0]  <= rd_issue;
      pipe_id[0] <= m1_ready ? ID_M1 : ID_M0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
    end
  end

  assign rsp_hit      = pipe_v[RD_LATENCY-1] & ~reset;
  assign m0_rsp_valid = rsp_hit & (pipe_id[RD_LATENCY-1] == ID_M0);
  assign m1_rsp_valid = rsp_hit & (pipe_id[RD_LATENCY-1] == ID_M1);
  assign m0_rsp_data  = m0_rsp_valid ? sram_dout : '0;
  assign m1_rsp_data  = m1_rsp_valid ? sram_dout : '0;

endmodule

// File: tb/tb_std_sram_singleport_arbiter.sv
// Bench for std_sram_singleport_arbiter: a swept/2-cycle instance and a no-sweep/1-cycle instance,
// each with a behavioural SRAM; read responses are tracked in an expected-response queue.
module tb_std_sram_singleport_arbiter;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          init_done;
  logic          m0_valid, m0_ready, m0_we, m0_rsp_valid;
  logic          m1_valid, m1_ready, m1_we, m1_rsp_valid;
  logic [AW-1:0] m0_addr, m1_addr, sram_addr;
  logic [DW-1:0] m0_din, m1_din, m0_rsp_data, m1_rsp_data, sram_din, sram_dout;
  logic          sram_en, sram_we, sram_regrstn;

  logic          rst1;
  logic          b_init_done;
  logic          b_m0_valid, b_m0_ready, b_m0_we, b_m0_rsp_valid;
  logic          b_m1_valid, b_m1_ready, b_m1_we, b_m1_rsp_valid;
  logic [AW-1:0] b_m0_addr, b_m1_addr, b_sram_addr;
  logic [DW-1:0] b_m0_din, b_m1_din, b_m0_rsp_data, b_m1_rsp_data, b_sram_din, b_sram_dout;
  logic          b_sram_en, b_sram_we, b_sram_regrstn;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 0;

  logic [DW-1:0] ref_a [DEPTH];

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t sb[$];

  std_sram_singleport_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .INIT_ENABLE(1), .INIT_VALUE(32'h0)
  ) dut_a (
    .clk(clk), .reset(rst), .init_done(init_done),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_dout(sram_dout), .sram_regrstn(sram_regrstn)
  );

  std_sram_singleport_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .INIT_ENABLE(0), .INIT_VALUE(32'h0)
  ) dut_b (
    .clk(clk), .reset(rst1), .init_done(b_init_done),
    .m0_valid(b_m0_valid), .m0_ready(b_m0_ready), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_din(b_m0_din),
    .m0_rsp_valid(b_m0_rsp_valid), .m0_rsp_data(b_m0_rsp_data),
    .m1_valid(b_m1_valid), .m1_ready(b_m1_ready), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_din(b_m1_din),
    .m1_rsp_valid(b_m1_rsp_valid), .m1_rsp_data(b_m1_rsp_data),
    .sram_en(b_sram_en), .sram_we(b_sram_we), .sram_addr(b_sram_addr), .sram_din(b_sram_din),
    .sram_dout(b_sram_dout), .sram_regrstn(b_sram_regrstn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // behavioural SRAMs: registered output, extra stage on the 2-cycle macro
  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] ra_s1, ra_s2;
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem_a[sram_addr] <= sram_din;
      else         ra_s1 <= mem_a[sram_addr];
    end
    ra_s2 <= ra_s1;
  end
  assign sram_dout = ra_s2;

  logic [DW-1:0] mem_b [DEPTH];
  logic [DW-1:0] rb_s1;
  always @(posedge clk) begin
    if (b_sram_en) begin
      if (b_sram_we) mem_b[b_sram_addr] <= b_sram_din;
      else           rb_s1 <= mem_b[b_sram_addr];
    end
  end
  assign b_sram_dout = rb_s1;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      checks++;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        if ({m1_rsp_valid, m0_rsp_valid} !== {e.id, ~e.id} ||
            (e.id ? m1_rsp_data : m0_rsp_data) !== e.data) begin
          errors++;
          $display("FAIL rsp cyc=%0d got v1v0=%b%b d0=%h d1=%h want id=%0d data=%h",
                   cyc, m1_rsp_valid, m0_rsp_valid, m0_rsp_data, m1_rsp_data, e.id, e.data);
        end
      end else if (m0_rsp_valid !== 1'b0 || m1_rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rsp_spurious cyc=%0d got v1v0=%b%b want 00", cyc, m1_rsp_valid, m0_rsp_valid);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v0, input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    m0_valid = v0; m0_we = we0; m0_addr = a0; m0_din = d0;
    m1_valid = v1; m1_we = we1; m1_addr = a1; m1_din = d1;
  endtask

  task automatic test_reset();
    repeat (2) next_cycle();
    mon_en = 1;
    @(negedge clk);
    checks++;
    if ({m0_ready, m1_ready, init_done, sram_en, sram_we, sram_regrstn} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_outputs got r0 r1 done en we rgn=%b%b%b%b%b%b want 000000",
               m0_ready, m1_ready, init_done, sram_en, sram_we, sram_regrstn);
    end
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_a[i] = '0;
  endtask

  task automatic test_init_sweep();
    drive_a(1'b1, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd0, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      checks++;
      if (sram_en !== 1'b1 || sram_we !== 1'b1 || sram_addr !== AW'(i) || sram_din !== 32'd0) begin
        errors++;
        $display("FAIL init_sweep i=%0d got en=%b we=%b addr=%0d din=%h want 1 1 %0d 0",
                 i, sram_en, sram_we, sram_addr, sram_din, i);
      end
      checks++;
      if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || init_done !== 1'b0) begin
        errors++;
        $display("FAIL init_no_ready i=%0d got r0=%b r1=%b done=%b want 0 0 0", i, m0_ready, m1_ready, init_done);
      end
      if (i == DEPTH - 1) drive_a(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (init_done !== 1'b1 || sram_en !== 1'b0) begin
      errors++;
      $display("FAIL init_done_rise got done=%b en=%b want 1 0", init_done, sram_en);
    end
    next_cycle();
  endtask

  task automatic test_single_read();
    drive_a(1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || sram_en !== 1'b1 || sram_we !== 1'b1 ||
        sram_addr !== 4'd3 || sram_din !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_write got r0=%b r1=%b en=%b we=%b addr=%0d din=%h want 1 0 1 1 3 deadbeef",
               m0_ready, m1_ready, sram_en, sram_we, sram_addr, sram_din);
    end
    ref_a[3] = 32'hDEADBEEF;
    next_cycle();
    drive_a(1'b1, 1'b0, 4'd3, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (m0_ready !== 1'b1 || sram_en !== 1'b1 || sram_we !== 1'b0 || sram_addr !== 4'd3) begin
      errors++;
      $display("FAIL single_read_issue got r0=%b en=%b we=%b addr=%0d want 1 1 0 3", m0_ready, sram_en, sram_we, sram_addr);
    end
    sb.push_back('{id: 1'b0, data: ref_a[3], due: cyc + 2});
    next_cycle();
    drive_a(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    repeat (3) next_cycle();
  endtask

  task automatic test_contention();
    logic g1;
    drive_a(1'b1, 1'b1, 4'd1, 32'h1111_0001, 1'b0, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
      errors++;
      $display("FAIL cont_wr0 got r0=%b r1=%b want 1 0", m0_ready, m1_ready);
    end
    ref_a[1] = 32'h1111_0001;
    next_cycle();
    drive_a(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b1, 4'd2, 32'h2222_0002);
    @(negedge clk);
    checks++;
    if (m0_ready !== 1'b0 || m1_ready !== 1'b1) begin
      errors++;
      $display("FAIL cont_wr1 got r0=%b r1=%b want 0 1", m0_ready, m1_ready);
    end
    ref_a[2] = 32'h2222_0002;
    next_cycle();
    drive_a(1'b1, 1'b0, 4'd1, 32'd0, 1'b1, 1'b0, 4'd2, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      g1 = (i % 2 == 1);
      checks++;
      if (m0_ready !== ~g1 || m1_ready !== g1 || sram_addr !== (g1 ? 4'd2 : 4'd1)) begin
        errors++;
        $display("FAIL cont_grant i=%0d got r0=%b r1=%b addr=%0d want r1=%b", i, m0_ready, m1_ready, sram_addr, g1);
      end
      sb.push_back('{id: g1, data: (g1 ? ref_a[2] : ref_a[1]), due: cyc + 2});
      next_cycle();
    end
    drive_a(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    repeat (3) next_cycle();
  endtask

  task automatic test_starvation();
    logic g1;
    for (int i = 0; i < 8; i++) begin
      g1 = (i == 3);
      drive_a(1'b1, 1'b0, 4'd1, 32'd0, g1, 1'b0, 4'd2, 32'd0);
      @(negedge clk);
      checks++;
      if (m0_ready !== ~g1 || m1_ready !== g1) begin
        errors++;
        $display("FAIL starve_grant i=%0d got r0=%b r1=%b want r1=%b", i, m0_ready, m1_ready, g1);
      end
      sb.push_back('{id: g1, data: (g1 ? ref_a[2] : ref_a[1]), due: cyc + 2});
      next_cycle();
    end
    drive_a(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    repeat (3) next_cycle();
  endtask

  task automatic test_reset_midflight();
    int due;
    drive_a(1'b1, 1'b0, 4'd3, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (m0_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_issue got r0=%b want 1", m0_ready);
    end
    due = cyc + 2;
    next_cycle();
    rst = 1'b1;
    drive_a(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (sram_en !== 1'b0 || init_done !== 1'b0 || m0_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_in_reset got en=%b done=%b r0=%b want 0 0 0", sram_en, init_done, m0_ready);
    end
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_a[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (cyc != due || m0_rsp_valid !== 1'b0 || m1_rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL mid_dropped cyc=%0d due=%0d got v0=%b v1=%b want 0 0", cyc, due, m0_rsp_valid, m1_rsp_valid);
        end
      end
      checks++;
      if (sram_en !== 1'b1 || sram_we !== 1'b1 || sram_addr !== AW'(i) || init_done !== 1'b0) begin
        errors++;
        $display("FAIL mid_resweep i=%0d got en=%b we=%b addr=%0d done=%b want 1 1 %0d 0",
                 i, sram_en, sram_we, sram_addr, init_done, i);
      end
      next_cycle();
    end
    drive_a(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd3, 32'd0);
    @(negedge clk);
    checks++;
    if (init_done !== 1'b1 || m1_ready !== 1'b1 || m0_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_after got done=%b r0=%b r1=%b want 1 0 1", init_done, m0_ready, m1_ready);
    end
    sb.push_back('{id: 1'b1, data: ref_a[3], due: cyc + 2});
    next_cycle();
    drive_a(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    repeat (3) next_cycle();
  endtask

  task automatic test_no_init();
    rst1 = 1'b0;
    b_m0_valid = 1'b1; b_m0_we = 1'b1; b_m0_addr = 4'd5; b_m0_din = 32'h12345678;
    @(negedge clk);
    checks++;
    if (b_init_done !== 1'b0 || b_m0_ready !== 1'b0 || b_sram_en !== 1'b0) begin
      errors++;
      $display("FAIL noinit_first got done=%b r0=%b en=%b want 0 0 0", b_init_done, b_m0_ready, b_sram_en);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (b_init_done !== 1'b1 || b_m0_ready !== 1'b1 || b_sram_we !== 1'b1 || b_sram_addr !== 4'd5) begin
      errors++;
      $display("FAIL noinit_write got done=%b r0=%b we=%b addr=%0d want 1 1 1 5", b_init_done, b_m0_ready, b_sram_we, b_sram_addr);
    end
    next_cycle();
    b_m0_we = 1'b0; b_m0_din = 32'd0;
    @(negedge clk);
    checks++;
    if (b_m0_ready !== 1'b1 || b_sram_we !== 1'b0 || b_m0_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL noinit_read got r0=%b we=%b rv=%b want 1 0 0", b_m0_ready, b_sram_we, b_m0_rsp_valid);
    end
    next_cycle();
    b_m0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (b_m0_rsp_valid !== 1'b1 || b_m0_rsp_data !== 32'h12345678 || b_m1_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL noinit_rsp got v0=%b d0=%h v1=%b want 1 12345678 0", b_m0_rsp_valid, b_m0_rsp_data, b_m1_rsp_valid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (b_m0_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL noinit_pulse got v0=%b want 0", b_m0_rsp_valid);
    end
    next_cycle();
  endtask

  initial begin
    rst  = 1'b1;
    rst1 = 1'b1;
    drive_a(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    b_m0_valid = 1'b0; b_m0_we = 1'b0; b_m0_addr = '0; b_m0_din = '0;
    b_m1_valid = 1'b0; b_m1_we = 1'b0; b_m1_addr = '0; b_m1_din = '0;
    test_reset();
    test_init_sweep();
    test_single_read();
    test_contention();
    test_starvation();
    test_reset_midflight();
    test_no_init();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drained got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
